// File: rtl/beat_rate_meter.sv
// Beat-to-beat interval meter: refractory rejection, 4-interval average and
// sequential restoring division of 60*SAMPLE_HZ into beats per minute.
module beat_rate_meter #(
  parameter int SAMPLE_HZ = 250,
  parameter int CNT_W     = 12,
  parameter int REFRACT   = 50,
  parameter int TIMEOUT   = 750
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             peak,
  output logic             beat,
  output logic [CNT_W-1:0] interval,
  output logic [7:0]       bpm,
  output logic             bpm_stb,
  output logic             flatline
);

  localparam logic [15:0]      K_C       = 16'(60 * SAMPLE_HZ);
  localparam logic [CNT_W-1:0] REFRACT_C = CNT_W'(REFRACT);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    RUN        = 2'd1,
    DIV        = 2'd2
  } state_t;

  state_t           state_r, state_n_s;
  logic             peak_q_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] hist_r [0:3];
  logic [2:0]       hist_n_r;
  logic [CNT_W-1:0] div_r;
  logic [CNT_W-1:0] rem_r;
  logic [15:0]      quo_r;
  logic [15:0]      dvd_r;
  logic [4:0]       bit_r;
  logic             pend_r, pend_n_s;

  logic             rise_s, timeout_s, first_s, acc_s, start_s, stb_s, done_s;
  logic [CNT_W+1:0] sum_s;
  logic [CNT_W-1:0] avg_s;
  logic [CNT_W:0]   trial_s;
  logic             ge_s;
  logic [CNT_W-1:0] rem_n_s;

  // Event detection, averaging, divider step and next-state control
  always_comb begin
    rise_s    = peak & ~peak_q_r;
    timeout_s = (state_r != WAIT_FIRST) && (cnt_r == TIMEOUT_C);
    done_s    = (state_r == DIV) && (bit_r == 5'd16);
    first_s   = 1'b0;
    acc_s     = 1'b0;
    start_s   = 1'b0;
    stb_s     = 1'b0;
    state_n_s = state_r;
    pend_n_s  = pend_r;

    // An accepted beat shifts the current count in and drops the oldest entry
    if (acc_s == 1'b0 && rise_s && !timeout_s && (state_r != WAIT_FIRST) && (cnt_r >= REFRACT_C)) begin
      acc_s = 1'b1;
    end else begin
      acc_s = 1'b0;
    end
    if (acc_s) begin
      sum_s = {2'b00, cnt_r} + {2'b00, hist_r[0]} + {2'b00, hist_r[1]} + {2'b00, hist_r[2]};
    end else begin
      sum_s = {2'b00, hist_r[0]} + {2'b00, hist_r[1]} + {2'b00, hist_r[2]} + {2'b00, hist_r[3]};
    end
    avg_s = CNT_W'(sum_s >> 2);

    trial_s = {rem_r, dvd_r[15]};
    ge_s    = (trial_s >= {1'b0, div_r});
    if (ge_s) begin
      rem_n_s = CNT_W'(trial_s - {1'b0, div_r});
    end else begin
      rem_n_s = CNT_W'(trial_s);
    end

    case (state_r)
      WAIT_FIRST: begin
        if (rise_s) begin
          first_s   = 1'b1;
          state_n_s = RUN;
        end else begin
          state_n_s = WAIT_FIRST;
        end
      end
      RUN: begin
        if (timeout_s) begin
          state_n_s = WAIT_FIRST;
        end else if (acc_s && (hist_n_r >= 3'd3)) begin
          start_s   = 1'b1;
          state_n_s = DIV;
        end else begin
          state_n_s = RUN;
        end
      end
      DIV: begin
        if (timeout_s) begin
          pend_n_s  = 1'b0;
          state_n_s = WAIT_FIRST;
        end else if (done_s) begin
          stb_s    = 1'b1;
          pend_n_s = 1'b0;
          if (pend_r || acc_s) begin
            start_s   = 1'b1;
            state_n_s = DIV;
          end else begin
            state_n_s = RUN;
          end
        end else if (acc_s) begin
          pend_n_s = 1'b1;
        end else begin
          pend_n_s = pend_r;
        end
      end
      default: begin
        state_n_s = WAIT_FIRST;
        pend_n_s  = 1'b0;
      end
    endcase
  end

  // State, counter, history, divider and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= WAIT_FIRST;
      peak_q_r <= 1'b0;
      cnt_r    <= '0;
      for (int i = 0; i < 4; i++) hist_r[i] <= '0;
      hist_n_r <= 3'd0;
      div_r    <= '0;
      rem_r    <= '0;
      quo_r    <= 16'd0;
      dvd_r    <= 16'd0;
      bit_r    <= 5'd0;
      pend_r   <= 1'b0;
      beat     <= 1'b0;
      interval <= '0;
      bpm      <= 8'd0;
      bpm_stb  <= 1'b0;
      flatline <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      pend_r   <= pend_n_s;
      peak_q_r <= peak;
      beat     <= first_s | acc_s;
      bpm_stb  <= stb_s;

      // Clearing wins over a tick landing in the same cycle
      if (first_s || acc_s) begin
        cnt_r <= '0;
      end else if (tick && (cnt_r < TIMEOUT_C)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end

      if (first_s) begin
        flatline <= 1'b0;
      end

      if (acc_s) begin
        interval  <= cnt_r;
        hist_r[0] <= cnt_r;
        hist_r[1] <= hist_r[0];
        hist_r[2] <= hist_r[1];
        hist_r[3] <= hist_r[2];
        hist_n_r  <= (hist_n_r == 3'd4) ? 3'd4 : hist_n_r + 3'd1;
      end else if (timeout_s) begin
        for (int i = 0; i < 4; i++) hist_r[i] <= '0;
        hist_n_r <= 3'd0;
        flatline <= 1'b1;
        bpm      <= 8'd0;
      end

      if (start_s) begin
        div_r <= avg_s;
        dvd_r <= K_C;
        rem_r <= '0;
        quo_r <= 16'd0;
        bit_r <= 5'd0;
      end else if ((state_r == DIV) && (bit_r < 5'd16)) begin
        dvd_r <= {dvd_r[14:0], 1'b0};
        rem_r <= rem_n_s;
        quo_r <= {quo_r[14:0], ge_s};
        bit_r <= bit_r + 5'd1;
      end

      if (stb_s) begin
        bpm <= (quo_r > 16'd255) ? 8'd255 : quo_r[7:0];
      end
    end
  end

endmodule
